// File: rtl/overlay_writer.sv
// overlay_writer
//    Packs a byte-wide overlay download stream into 16-bit words, buffers them
//    in a small FIFO and writes each word to an SDRAM channel with a
//    req/ack handshake. Signals overlay_valid once a download has finished
//    and every buffered word has reached memory.
//
// Parameters
//    FIFO_DEPTH   word entries in the write FIFO (2..16)
//    WAIT_LEVEL   FIFO occupancy at or above which ioctl_wait is raised
//
// Ports
//    clk_sys          in   single clock, rising edge
//    reset            in   synchronous, active-high
//    ioctl_download   in   download active
//    ioctl_wr         in   byte strobe
//    ioctl_addr[24:0] in   byte address
//    ioctl_dout[7:0]  in   download byte
//    ioctl_wait       out  back-pressure to the download source
//    mem_req          out  one-cycle write request pulse
//    mem_addr[23:0]   out  word address, held until mem_ack
//    mem_din[15:0]    out  write word {high byte, low byte}, held until mem_ack
//    mem_ack          in   one-cycle write-complete pulse
//    overlay_valid    out  overlay fully written
//    overflow         out  sticky: a word was dropped on a full FIFO
//    checksum[15:0]   out  running sum of written words
//
// Build option
//    OVERLAY_WRITER_CHECKSUM_EN  when defined, checksum accumulates mem_din on
//                                every accepted mem_ack; otherwise it is tied
//                                to zero and no adder exists.

module overlay_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int WAIT_LEVEL = FIFO_DEPTH - 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic        mem_ack,
   output logic        overlay_valid,
   output logic        overflow,
   output logic [15:0] checksum
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_LEVEL);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // FIFO entry: {word address[23:0], high byte, low byte}
   logic [39:0] fifo_mem [FIFO_DEPTH];

   state_t           state_q, state_d;
   logic             mem_req_q, mem_req_d;
   logic [23:0]      mem_addr_q, mem_addr_d;
   logic [15:0]      mem_din_q, mem_din_d;
   logic             wait_q, wait_d;
   logic             overlay_valid_q, overlay_valid_d;
   logic             overflow_q, overflow_d;
   logic             words_written_q, words_written_d;
   logic             pending_q, pending_d;
   logic             flush_q, flush_d;
   logic             download_q, download_d;
   logic [7:0]       low_byte_q, low_byte_d;
   logic [23:0]      low_addr_q, low_addr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
   logic [15:0]      checksum_q, checksum_d;
`endif

   logic        dl_rise, dl_fall, wr_even, wr_odd, pend_eff;
   logic        push, push_ok, pop;
   logic [39:0] push_data, head;

   assign dl_rise  = ioctl_download & ~download_q;
   assign dl_fall  = ~ioctl_download & download_q;
   assign wr_even  = ioctl_wr & ioctl_download & ~ioctl_addr[0];
   assign wr_odd   = ioctl_wr & ioctl_download & ioctl_addr[0];
   // A rising edge wipes the pending low byte in the same cycle.
   assign pend_eff = pending_q & ~dl_rise;
   assign head     = fifo_mem[rd_ptr_q];

   always_comb begin
      download_d      = ioctl_download;
      flush_d         = 1'b0;
      pending_d       = pending_q;
      low_byte_d      = low_byte_q;
      low_addr_d      = low_addr_q;
      overlay_valid_d = overlay_valid_q;
      overflow_d      = overflow_q;
      words_written_d = words_written_q;
      state_d         = state_q;
      mem_req_d       = 1'b0;
      mem_addr_d      = mem_addr_q;
      mem_din_d       = mem_din_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      push            = 1'b0;
      push_ok         = 1'b0;
      push_data       = '0;
      pop             = 1'b0;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
      checksum_d      = checksum_q;
`endif

      if (dl_rise) begin
         overlay_valid_d = 1'b0;
         overflow_d      = 1'b0;
         words_written_d = 1'b0;
         pending_d       = 1'b0;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
         checksum_d      = '0;
`endif
      end

      // A dangling low byte at the end of a download is flushed next cycle.
      if (dl_fall) begin
         flush_d   = pending_q;
         pending_d = 1'b0;
      end

      if (flush_q) begin
         push      = 1'b1;
         push_data = {low_addr_q, 8'h00, low_byte_q};
      end

      if (wr_even) begin
         low_byte_d = ioctl_dout;
         low_addr_d = ioctl_addr[24:1];
         pending_d  = 1'b1;
      end

      if (wr_odd) begin
         pending_d = 1'b0;
         // The flush slot owns the push port; a colliding word is dropped.
         if (flush_q) begin
            overflow_d = 1'b1;
         end else begin
            push      = 1'b1;
            push_data = {ioctl_addr[24:1], ioctl_dout, pend_eff ? low_byte_q : 8'h00};
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               state_d    = S_REQ;
               mem_addr_d = head[39:16];
               mem_din_d  = head[15:0];
            end
         end
         S_REQ: begin
            state_d   = S_WAIT_ACK;
            mem_req_d = 1'b1;
         end
         S_WAIT_ACK: begin
            if (mem_ack) begin
               state_d         = S_IDLE;
               words_written_d = 1'b1;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
               checksum_d      = checksum_q + mem_din_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_ok = push & ~((count_q == FULL_CNT) & ~pop);
      if (push & ~push_ok) overflow_d = 1'b1;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok & ~pop) count_d = count_q + 1'b1;
      else if (~push_ok & pop) count_d = count_q - 1'b1;

      wait_d = (count_d >= WAIT_CNT);

      if (~ioctl_download && (count_q == '0) && (state_q == S_IDLE) &&
          ~flush_q && ~pending_q && words_written_q)
         overlay_valid_d = 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q         <= S_IDLE;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= '0;
         mem_din_q       <= '0;
         wait_q          <= 1'b0;
         overlay_valid_q <= 1'b0;
         overflow_q      <= 1'b0;
         words_written_q <= 1'b0;
         pending_q       <= 1'b0;
         flush_q         <= 1'b0;
         // Track the live level so a download held through reset shows no edge.
         download_q      <= ioctl_download;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
         checksum_q      <= '0;
`endif
      end else begin
         state_q         <= state_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         mem_din_q       <= mem_din_d;
         wait_q          <= wait_d;
         overlay_valid_q <= overlay_valid_d;
         overflow_q      <= overflow_d;
         words_written_q <= words_written_d;
         pending_q       <= pending_d;
         flush_q         <= flush_d;
         download_q      <= download_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
         checksum_q      <= checksum_d;
`endif
      end
   end

   // Data-only storage, meaningful only under the control flops above.
   always_ff @(posedge clk_sys) begin
      low_byte_q <= low_byte_d;
      low_addr_q <= low_addr_d;
      if (~reset & push_ok) fifo_mem[wr_ptr_q] <= push_data;
   end

   assign ioctl_wait    = wait_q;
   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;
   assign mem_din       = mem_din_q;
   assign overlay_valid = overlay_valid_q;
   assign overflow      = overflow_q;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
   assign checksum      = checksum_q;
`else
   assign checksum      = '0;
`endif

endmodule

// File: tb/tb_overlay_writer.sv
// Self-checking bench for overlay_writer: a byte-pairing/checksum model driven
// from the stimulus, a per-cycle compare/responder process, and directed
// literal expectations for the documented scenarios.

module tb_overlay_writer;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_ack;
   logic        overlay_valid;
   logic        overflow;
   logic [15:0] checksum;

   overlay_writer #(.FIFO_DEPTH(4)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_ack        (mem_ack),
      .overlay_valid  (overlay_valid),
      .overflow       (overflow),
      .checksum       (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [39:0] exp_q[$];
   logic [23:0] req_addr_log[$];
   logic [15:0] req_din_log[$];
   logic        m_pending = 1'b0;
   logic [7:0]  m_low = 8'h00;
   logic [23:0] m_low_addr = 24'h0;
   logic [15:0] m_csum = 16'h0;
   int          req_count = 0;
   bit          model_on = 1'b1;
   bit          ack_en = 1'b1;
   int          ack_dly = 1;
   bit          force_ack = 1'b0;
   bit          saw_wait = 1'b0;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process plus SDRAM responder, all on the falling edge.
   initial begin : cmp
      logic        prev_req;
      logic        dl_seen;
      logic        outstanding;
      int          cnt;
      logic [15:0] cur_din;
      logic [39:0] e;
      prev_req = 1'b0; dl_seen = 1'b0; outstanding = 1'b0; cnt = 0; cur_din = 16'h0;
      mem_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         mem_ack = force_ack;
         if (reset) begin
            outstanding = 1'b0;
            m_csum = 16'h0;
            exp_q.delete();
         end else begin
            if (model_on) chk("checksum", 40'(checksum), 40'(m_csum));
            if (mem_req) begin
               req_count++;
               req_addr_log.push_back(mem_addr);
               req_din_log.push_back(mem_din);
               chk("req_single_cycle", 40'(prev_req), 40'h0);
               if (model_on) begin
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_req: got addr %0h din %0h expected no request", mem_addr, mem_din);
                  end else begin
                     e = exp_q.pop_front();
                     chk("mem_addr", 40'(mem_addr), 40'(e[39:16]));
                     chk("mem_din", 40'(mem_din), 40'(e[15:0]));
                     cur_din = e[15:0];
                  end
               end
               outstanding = 1'b1;
               cnt = 0;
            end
            if (outstanding && ack_en) begin
               cnt++;
               if (cnt >= ack_dly) begin
                  mem_ack = 1'b1;
                  outstanding = 1'b0;
`ifdef OVERLAY_WRITER_CHECKSUM_EN
                  if (model_on) m_csum = m_csum + cur_din;
`endif
               end
            end
            if (!dl_seen && ioctl_download) m_csum = 16'h0;
         end
         prev_req = mem_req;
         dl_seen = ioctl_download;
      end
   end

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honor);
      int n;
      n = 0;
      while (honor && ioctl_wait && n < 200) begin
         saw_wait = 1'b1;
         @(posedge clk_sys); #1;
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL wait_timeout: ioctl_wait still %0b after %0d cycles, required release", ioctl_wait, n);
      end
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      if (ioctl_download) begin
         if (!a[0]) begin
            m_pending = 1'b1; m_low = d; m_low_addr = a[24:1];
         end else begin
            exp_q.push_back({a[24:1], d, m_pending ? m_low : 8'h00});
            m_pending = 1'b0;
         end
      end
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic send_word(input int idx, input logic [15:0] w, input bit honor);
      send_byte(25'(2 * idx), w[7:0], honor);
      send_byte(25'(2 * idx + 1), w[15:8], honor);
   endtask

   task automatic start_download();
      ioctl_download = 1'b1;
      m_pending = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   task automatic end_download();
      ioctl_download = 1'b0;
      if (m_pending) exp_q.push_back({m_low_addr, 8'h00, m_low});
      m_pending = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!overlay_valid && n < 60) begin
         @(posedge clk_sys); #1;
         n++;
      end
      chk(name, 40'(overlay_valid), 40'h1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ioctl_wait"}, 40'(ioctl_wait), 40'h0);
      chk({tag, "_mem_req"}, 40'(mem_req), 40'h0);
      chk({tag, "_mem_addr"}, 40'(mem_addr), 40'h0);
      chk({tag, "_mem_din"}, 40'(mem_din), 40'h0);
      chk({tag, "_overlay_valid"}, 40'(overlay_valid), 40'h0);
      chk({tag, "_overflow"}, 40'(overflow), 40'h0);
      chk({tag, "_checksum"}, 40'(checksum), 40'h0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   initial begin : main
      int base;
      int rc;
      int n;
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0;

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;
      @(posedge clk_sys); #1;

      // Single word 0x2211 at word address 0, 3-cycle latency
      ack_dly = 1;
      start_download();
      send_byte(25'd0, 8'h11, 1'b0);
      send_byte(25'd1, 8'h22, 1'b0);
      @(negedge clk_sys); chk("lat_c1_req", 40'(mem_req), 40'h0);
      @(negedge clk_sys); chk("lat_c2_req", 40'(mem_req), 40'h0);
      @(negedge clk_sys); chk("lat_c3_req", 40'(mem_req), 40'h1);
      chk("lat_c3_addr", 40'(mem_addr), 40'h0);
      chk("lat_c3_din", 40'(mem_din), 40'h2211);
      @(posedge clk_sys); #1;
      end_download();
      wait_valid("single_valid");

      // Five bytes, odd tail flushed with 0x00 high byte
      base = req_addr_log.size();
      ack_dly = 2;
      start_download();
      for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(i + 1), 1'b0);
      end_download();
      wait_valid("five_valid");
      chk("five_count", 40'(req_addr_log.size() - base), 40'd3);
      if (req_addr_log.size() - base == 3) begin
         chk("five_w0_addr", 40'(req_addr_log[base]), 40'h0);
         chk("five_w0_din", 40'(req_din_log[base]), 40'h0201);
         chk("five_w1_addr", 40'(req_addr_log[base + 1]), 40'h1);
         chk("five_w1_din", 40'(req_din_log[base + 1]), 40'h0403);
         chk("five_w2_addr", 40'(req_addr_log[base + 2]), 40'h2);
         chk("five_w2_din", 40'(req_din_log[base + 2]), 40'h0005);
      end

      // Empty download pulse
      rc = req_count;
      start_download();
      repeat (3) @(posedge clk_sys);
      #1;
      end_download();
      for (int i = 0; i < 8; i++) begin
         chk("empty_valid", 40'(overlay_valid), 40'h0);
         @(posedge clk_sys); #1;
      end
      chk("empty_no_req", 40'(req_count - rc), 40'h0);

      // Checksum of 0xFFFF + 0x0002
      ack_dly = 1;
      start_download();
      send_word(0, 16'hFFFF, 1'b0);
      send_word(1, 16'h0002, 1'b0);
      end_download();
      wait_valid("csum_valid");
`ifdef OVERLAY_WRITER_CHECKSUM_EN
      chk("csum_literal", 40'(checksum), 40'h0001);
`else
      chk("csum_literal", 40'(checksum), 40'h0000);
`endif

      // Compliant source under withheld acks
      rc = req_count;
      ack_en = 1'b0; ack_dly = 2; saw_wait = 1'b0;
      start_download();
      fork
         begin
            for (int i = 0; i < 10; i++) send_word(i, 16'(16'hA000 + i), 1'b1);
         end
         begin
            repeat (30) @(posedge clk_sys);
            ack_en = 1'b1;
         end
      join
      end_download();
      wait_valid("compliant_valid");
      chk("compliant_saw_wait", 40'(saw_wait), 40'h1);
      chk("compliant_overflow", 40'(overflow), 40'h0);
      chk("compliant_req_count", 40'(req_count - rc), 40'd10);

      // Non-compliant source overruns the FIFO
      ack_en = 1'b0; model_on = 1'b0;
      start_download();
      for (int i = 0; i < 10; i++) send_word(i, 16'(16'hB000 + i), 1'b0);
      chk("overrun_overflow", 40'(overflow), 40'h1);
      chk("overrun_wait", 40'(ioctl_wait), 40'h1);
      ack_en = 1'b1;
      repeat (40) @(posedge clk_sys);
      #1;
      exp_q.delete();
      end_download();
      repeat (5) @(posedge clk_sys);
      #1;

      // Reset during WAIT_ACK with download held, then a stray ack
      ack_en = 1'b0;
      start_download();
      model_on = 1'b1;
      rc = req_count;
      send_word(0, 16'h6655, 1'b0);
      n = 0;
      while (req_count == rc && n < 20) begin
         @(posedge clk_sys); #1;
         n++;
      end
      chk("rst_req_seen", 40'(req_count - rc), 40'd1);
      reset = 1'b1; m_pending = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      chk_all_zero("in_reset");
      reset = 1'b0;
      force_ack = 1'b1;
      @(posedge clk_sys); #1;
      force_ack = 1'b0;
      rc = req_count;
      repeat (10) @(posedge clk_sys);
      #1;
      chk("stray_no_req", 40'(req_count - rc), 40'h0);
      chk_all_zero("after_stray");
      ack_en = 1'b1; ack_dly = 1;
      send_word(1, 16'h4433, 1'b0);
      end_download();
      wait_valid("resume_valid");
      chk("resume_req_count", 40'(req_count - rc), 40'd1);
      chk("resume_last_din", 40'(req_din_log[req_din_log.size() - 1]), 40'h4433);

      repeat (3) @(posedge clk_sys);
      #1;
      chk("model_drained", 40'(exp_q.size()), 40'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/overlay_writer.md
OVERLAY_WRITER -- requirements
Module: overlay_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of word entries in the write FIFO; legal values 2 to 16.
REQ-002 Parameter WAIT_LEVEL, default FIFO_DEPTH-1: FIFO occupancy at or above which ioctl_wait is asserted.
REQ-003 clk_sys  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  overlay download active.
REQ-006 ioctl_wr  in  1  byte strobe, one cycle per byte.
REQ-007 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 ioctl_wait  out  1  back-pressure to the download source.
REQ-010 mem_req  out  1  one-cycle write request pulse to the SDRAM channel.
REQ-011 mem_addr  out  24  word address; stable from mem_req until mem_ack.
REQ-012 mem_din  out  16  write word {high byte, low byte}; stable from mem_req until mem_ack.
REQ-013 mem_ack  in  1  one-cycle pulse: the current write has completed.
REQ-014 overlay_valid  out  1  overlay fully written and usable by the pixel fetcher.
REQ-015 overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
REQ-016 checksum  out  16  running sum of the written words (see Configuration).

Function
REQ-017 Byte pairing: ioctl_wr with ioctl_addr[0]=0 latches the low byte and sets the pending flag.
REQ-018 ioctl_wr with ioctl_addr[0]=1 pushes the entry {ioctl_addr[24:1], ioctl_dout, low byte} into the FIFO and clears the pending flag.
REQ-019 An odd-address byte with pending=0 uses a low byte of 0x00.
REQ-020 ioctl_wr with ioctl_download=0 is ignored.
REQ-021 Rising edge of ioctl_download: clear overlay_valid, overflow, checksum and pending in that cycle.
REQ-022 Falling edge of ioctl_download with pending=1: push {last even addr[24:1], 0x00, low byte} one cycle later.
REQ-023 ioctl_wait = (FIFO occupancy >= WAIT_LEVEL), registered.
REQ-024 Push while the FIFO is full and no pop occurs in the same cycle: drop the word and set overflow.
REQ-025 Push and pop in the same cycle: occupancy unchanged and the pushed word is retained.
REQ-026 FSM states IDLE, REQ and WAIT_ACK.
REQ-027 FSM transition IDLE->REQ when the FIFO is non-empty: pop the head into the mem_addr/mem_din registers.
REQ-028 FSM transition REQ->WAIT_ACK: mem_req=1 for exactly this one cycle.
REQ-029 FSM transition WAIT_ACK->IDLE on mem_ack.
REQ-030 Minimum spacing between mem_req pulses is 3 cycles.
REQ-031 mem_ack in IDLE or REQ is ignored.
REQ-032 overlay_valid is set 1 cycle after all of the following hold: ioctl_download=0, FIFO empty, FSM in IDLE, no pending flush, and at least one word written since the last download start.
REQ-033 A download that ends with zero words written leaves overlay_valid=0.
REQ-034 Latency from the odd-byte ioctl_wr to mem_req, with the FIFO empty and the FSM in IDLE, is 3 cycles.

Reset
REQ-035 While reset=1, all outputs are 0: ioctl_wait, mem_req, mem_addr, mem_din, overlay_valid, overflow and checksum.
REQ-036 While reset=1, the FIFO is empty, pending=0 and the FSM is in IDLE.
REQ-037 Reset during WAIT_ACK abandons the write; a later mem_ack is ignored per REQ-031.
REQ-038 Reset held while ioctl_download=1: after release, the download is treated as already active (no rising edge is seen), and bytes continue to be accepted.

Configuration
REQ-039 Macro OVERLAY_WRITER_CHECKSUM_EN.
REQ-040 When defined: checksum increments by mem_din modulo 2^16 on each mem_ack accepted in WAIT_ACK.
REQ-041 When undefined: checksum is constant 0 and no adder is synthesised.

Verification
REQ-042 Bytes 0x11,0x22 at addresses 0,1 -> mem_req 3 cycles later with mem_addr=0 and mem_din=0x2211; after mem_ack and download end, overlay_valid=1.
REQ-043 Download of 5 bytes (0x01..0x05) at addresses 0..4, then end -> three writes: 0x0201 @0, 0x0403 @1, 0x0005 @2.
REQ-044 mem_ack withheld, 10 back-to-back words -> ioctl_wait=1 once occupancy reaches 3; a source that ignores ioctl_wait sees overflow=1; a compliant source sees no drop and writes in address order.
REQ-045 Reset asserted in WAIT_ACK, then a stray mem_ack -> no further mem_req and all outputs 0.
REQ-046 Words 0xFFFF and 0x0002 written with CHECKSUM_EN defined -> checksum=0x0001; with the macro undefined -> checksum=0.
REQ-047 Download pulse with no ioctl_wr -> overlay_valid stays 0 and no mem_req is issued.
